// File: rtl/datapath_types.sv
// Pipeline hand-off types between fetch and decode, plus the fetch FSM states.
package datapath_types;

  localparam int BHR_WIDTH = 8;

  typedef struct packed {
    logic [31:0]          pc_reg;
    logic                 branch_guess;
    logic [BHR_WIDTH-1:0] branch_history;
    logic                 jump_det;
  } fetch_decode_block;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/rv32i_types.sv
// RV32I encoding constants shared by the front end.
package rv32i_types;

  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_predecode.sv
// Static next-PC prediction: JAL always taken, backward conditional branches taken.
module fetch_predecode
  import rv32i_types::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [31:0] next_pc,
  output logic        branch_guess,
  output logic        jump_det
);

  logic [31:0] j_imm_s;
  logic [31:0] b_imm_s;

  assign j_imm_s = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign b_imm_s = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

  // Opcode classification and target selection
  always_comb begin
    next_pc      = pc + 32'd4;
    branch_guess = 1'b0;
    jump_det     = 1'b0;
    case (instr[6:0])
      OP_JAL: begin
        jump_det     = 1'b1;
        branch_guess = 1'b1;
        next_pc      = pc + j_imm_s;
      end
      OP_BRANCH: begin
        if (b_imm_s[31]) begin
          branch_guess = 1'b1;
          next_pc      = pc + b_imm_s;
        end else begin
          branch_guess = 1'b0;
          next_pc      = pc + 32'd4;
        end
      end
      default: begin
        next_pc      = pc + 32'd4;
        branch_guess = 1'b0;
        jump_det     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding request, one-entry skid buffer, and
// a drain state that swallows the response of a request abandoned by redirect.
module fetch
  import rv32i_types::*;
  import datapath_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter int          BHR_W    = BHR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  output logic              imem_read,
  output logic [31:0]       imem_address,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_resp,
  output logic              out_valid,
  output fetch_decode_block out_block,
  output logic [31:0]       instr
);

  fetch_state_e      state_r;
  logic [31:0]       req_addr_r;
  logic [31:0]       pending_pc_r;
  logic [BHR_W-1:0]  bhr_r;
  fetch_decode_block skid_block_r;
  logic [31:0]       skid_instr_r;
  logic [31:0]       skid_next_r;

  logic [31:0]       pd_next_pc_s;
  logic              pd_guess_s;
  logic              pd_jump_s;
  logic              out_free_s;
  fetch_decode_block capture_s;

  fetch_predecode u_predecode (
    .pc           (req_addr_r),
    .instr        (imem_rdata),
    .next_pc      (pd_next_pc_s),
    .branch_guess (pd_guess_s),
    .jump_det     (pd_jump_s)
  );

  assign imem_read    = rst_n && (state_r != HOLD);
  assign imem_address = req_addr_r;
  assign out_free_s   = !out_valid || !stall;
  // History is the pre-shift value even when a branch resolves this cycle
  assign capture_s    = '{pc_reg: req_addr_r, branch_guess: pd_guess_s,
                          branch_history: bhr_r, jump_det: pd_jump_s};

  // Branch history shift register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bhr_r <= '0;
    end else if (resolve_valid) begin
      bhr_r <= {bhr_r[BHR_W-2:0], resolve_taken};
    end
  end

  // Request sequencing, output register and skid buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= FETCH;
      req_addr_r   <= RESET_PC;
      pending_pc_r <= RESET_PC;
      out_valid    <= 1'b0;
      out_block    <= '0;
      instr        <= NOP_INSTR;
      skid_block_r <= '0;
      skid_instr_r <= NOP_INSTR;
      skid_next_r  <= RESET_PC;
    end else if (redirect) begin
      out_valid <= 1'b0;
      // Only an in-flight request without its response forces a drain
      if (state_r != HOLD && !imem_resp) begin
        pending_pc_r <= redirect_pc;
        state_r      <= DRAIN;
      end else begin
        req_addr_r <= redirect_pc;
        state_r    <= FETCH;
      end
    end else begin
      case (state_r)
        FETCH: begin
          if (imem_resp && out_free_s) begin
            out_block  <= capture_s;
            instr      <= imem_rdata;
            out_valid  <= 1'b1;
            req_addr_r <= pd_next_pc_s;
          end else if (imem_resp) begin
            skid_block_r <= capture_s;
            skid_instr_r <= imem_rdata;
            skid_next_r  <= pd_next_pc_s;
            state_r      <= HOLD;
          end else if (!stall) begin
            out_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            out_block  <= skid_block_r;
            instr      <= skid_instr_r;
            out_valid  <= 1'b1;
            req_addr_r <= skid_next_r;
            state_r    <= FETCH;
          end
        end
        DRAIN: begin
          if (!stall) begin
            out_valid <= 1'b0;
          end
          if (imem_resp) begin
            req_addr_r <= pending_pc_r;
            state_r    <= FETCH;
          end
        end
        default: begin
          state_r <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000060, first fetch address after reset.
REQ-002 Parameter BHR_W, default 8, branch-history width; SHALL equal the branch_history field width of fetch_decode_block.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 stall  in  1  decode cannot accept; output register holds.
REQ-006 redirect  in  1  execute-stage mispredict/jump correction; highest priority.
REQ-007 redirect_pc  in  32  corrected fetch address.
REQ-008 resolve_valid  in  1  a conditional branch resolved this cycle.
REQ-009 resolve_taken  in  1  resolved branch direction.
REQ-010 imem_read  out  1  instruction-memory request.
REQ-011 imem_address  out  32  request address, stable while imem_read high.
REQ-012 imem_rdata  in  32  instruction word, valid with imem_resp.
REQ-013 imem_resp  in  1  single-cycle completion pulse.
REQ-014 out_valid  out  1  out_block/instr hold a real instruction (else bubble).
REQ-015 out_block  out  fetch_decode_block  pc_reg, branch_guess, branch_history, jump_det to decode.
REQ-016 instr  out  32  fetched instruction word to decode.

Function
REQ-017 FSM states SHALL be FETCH, HOLD, DRAIN.
REQ-018 FETCH: imem_read=1, imem_address=req_addr; imem_rdata accepted only on imem_resp.
REQ-019 On imem_resp without redirect, output register free (out_valid=0 or stall=0): load out_block/instr, out_valid=1, req_addr<=next_pc, stay FETCH.
REQ-020 On imem_resp without redirect, output register busy (out_valid=1 and stall=1): write word to one-entry skid buffer, go HOLD.
REQ-021 HOLD: imem_read=0; when stall=0, move skid buffer to output register, req_addr<=buffered next_pc, go FETCH.
REQ-022 Output register not loaded and stall=0: out_valid<=0 next cycle; stall=1: all output fields hold unchanged.
REQ-023 redirect in any state: out_valid<=0, skid buffer invalidated, pending_pc<=redirect_pc, same-cycle imem_resp data discarded.
REQ-024 redirect in FETCH with no imem_resp: go DRAIN; imem_read stays 1, imem_address unchanged until imem_resp.
REQ-025 DRAIN: on imem_resp discard data, req_addr<=pending_pc, go FETCH; further redirect in DRAIN only overwrites pending_pc.
REQ-026 redirect in FETCH with imem_resp, or in HOLD: req_addr<=redirect_pc, go FETCH.
REQ-027 Predecode: JAL (opcode 7'b1101111) -> jump_det=1, branch_guess=1, next_pc=pc+j_imm.
REQ-028 BRANCH (7'b1100011) with b_imm negative -> branch_guess=1, next_pc=pc+b_imm; non-negative -> branch_guess=0.
REQ-029 Others (incl. JALR): jump_det=0, branch_guess=0, next_pc=pc+4; all adds 32-bit modulo 2^32.
REQ-030 BHR: on resolve_valid, bhr<={bhr[BHR_W-2:0],resolve_taken}; branch_history = bhr value at word capture.
REQ-031 resolve_valid coincident with capture: captured branch_history SHALL be pre-shift bhr.
REQ-032 Latency: imem_resp in cycle N -> out_valid=1 in N+1; next request issued N+1.

Reset
REQ-033 rst_n=0 at clock edge: state=FETCH, req_addr=RESET_PC, out_valid=0, out_block=0, instr=32'h00000013 (NOP), bhr=0, skid buffer empty.
REQ-034 imem_read SHALL be 0 while rst_n=0; reset mid-request abandons it with no DRAIN.

Structure
REQ-035 fetch_decode_block, FSM state enum, opcode constants and NOP constant SHALL reside in datapath_types/rv32i_types packages.
REQ-036 Predecode (REQ-027..029) SHALL be one combinational sub-module, fetch_predecode.

Verification
REQ-037 Reset release, imem_resp 2 cycles after each read -> addresses 0x60, 0x64, 0x68; out_block.pc_reg matches, out_valid one cycle after each resp.
REQ-038 stall=1 for 4 cycles with output full, resp for 0x64 -> HOLD, imem_read=0, output holds 0x60; stall=0 -> 0x64 emitted next cycle, then read 0x68.
REQ-039 redirect to 0x200 while read of 0x70 pending -> DRAIN, address stays 0x70 until resp, data discarded, next read 0x200, no 0x70 bubble valid.
REQ-040 JAL at 0x100 with j_imm=-16 -> jump_det=1, branch_guess=1, next read 0xF0; BEQ with b_imm=+8 -> guess 0, next 0x104.
REQ-041 resolve_valid with taken 1,0,1 from bhr=0 -> bhr=8'b00000101; capture same cycle as third update carries 8'b00000010.
REQ-042 redirect and imem_resp in same cycle as stall=1 -> out_valid=0, resp data dropped, next read redirect_pc.
